// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shared backing-memory port arbiter for the Riscv151 fetch and data requesters
//
// Purpose:
//   Multiplexes the instruction-fetch requester (ic, read-only) and the data
//   requester (dc, read/write with byte enables) onto one memory port. Only one
//   transaction is outstanding at a time, sequenced by IDLE -> REQ -> (RESP) -> IDLE.
//   dc has fixed priority over ic. A streak counter bounds how many consecutive
//   dc grants may be made while ic is waiting, so fetch cannot starve.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ic_req_*            fetch request (valid/ready/addr)
//   ic_resp_*           fetch response (one-cycle valid pulse, held data)
//   dc_req_*            data request (valid/ready/addr/we/wdata); we = 0 means read
//   dc_resp_*           data response (one-cycle valid pulse; data is 0 for stores)
//   mem_req_*           memory request, fields held stable until mem_req_ready
//   mem_resp_*          memory read data return (only honoured in RESP)
//   busy                high whenever the FSM is not in IDLE
//
// Optional feature (macro RISCV_MEM_ARB_PERF_EN):
//   ic_grant_cnt, dc_grant_cnt  accepted requests per requester
//   ic_stall_cnt                cycles with ic_req_valid high and ic_req_ready low
//   All three are 32-bit wrapping counters cleared by reset. Arbitration is
//   identical whether or not the macro is defined.

module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DC_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    ic_req_valid,
  output logic                    ic_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ic_req_addr,
  output logic                    ic_resp_valid,
  output logic [DATA_WIDTH-1:0]   ic_resp_data,

  input  logic                    dc_req_valid,
  output logic                    dc_req_ready,
  input  logic [ADDR_WIDTH-1:0]   dc_req_addr,
  input  logic [DATA_WIDTH/8-1:0] dc_req_we,
  input  logic [DATA_WIDTH-1:0]   dc_req_wdata,
  output logic                    dc_resp_valid,
  output logic [DATA_WIDTH-1:0]   dc_resp_data,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH/8-1:0] mem_req_we,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,

  output logic                    busy
`ifdef RISCV_MEM_ARB_PERF_EN
  ,
  output logic [31:0]             ic_grant_cnt,
  output logic [31:0]             dc_grant_cnt,
  output logic [31:0]             ic_stall_cnt
`endif
);

  localparam int BE_WIDTH     = DATA_WIDTH / 8;
  localparam int STREAK_WIDTH = $clog2(MAX_DC_STREAK + 1);
  localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(MAX_DC_STREAK);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]              state;
  logic [STREAK_WIDTH-1:0] streak;
  logic [STREAK_WIDTH-1:0] streak_inc;
  logic                    owner_dc;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [BE_WIDTH-1:0]     req_we;
  logic [DATA_WIDTH-1:0]   req_wdata;

  logic in_idle;
  logic dc_wins;
  logic ic_wins;
  logic dc_accept;
  logic ic_accept;
  logic req_is_write;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // dc wins unless ic is also waiting and dc has already used its full streak.
  assign in_idle   = (state == ST_IDLE);
  assign dc_wins   = dc_req_valid && (!ic_req_valid || (streak < STREAK_LIMIT));
  assign ic_wins   = ic_req_valid && !dc_wins;

  assign dc_req_ready = in_idle && dc_wins;
  assign ic_req_ready = in_idle && ic_wins;

  assign dc_accept = dc_req_valid && dc_req_ready;
  assign ic_accept = ic_req_valid && ic_req_ready;

  // ic transactions always latch we = 0, so a non-zero mask means a dc store.
  assign req_is_write = |req_we;

  assign streak_inc = (streak >= STREAK_LIMIT) ? STREAK_LIMIT
                                               : streak + STREAK_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Memory-side outputs come straight from the latched request
  // ---------------------------------------------------------------------------
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = req_addr;
  assign mem_req_we    = req_we;
  assign mem_req_wdata = req_wdata;
  assign busy          = !in_idle;

  // ---------------------------------------------------------------------------
  // Transaction FSM, request latch, streak counter and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      streak        <= '0;
      owner_dc      <= 1'b0;
      req_addr      <= '0;
      req_we        <= '0;
      req_wdata     <= '0;
      ic_resp_valid <= 1'b0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_data  <= '0;
    end else begin
      // Response valids are single-cycle pulses; data registers hold.
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dc_accept) begin
            owner_dc  <= 1'b1;
            req_addr  <= dc_req_addr;
            req_we    <= dc_req_we;
            req_wdata <= dc_req_wdata;
            // The streak only grows while ic is actually being held off.
            streak    <= ic_req_valid ? streak_inc : '0;
            state     <= ST_REQ;
          end else if (ic_accept) begin
            owner_dc  <= 1'b0;
            req_addr  <= ic_req_addr;
            req_we    <= '0;
            req_wdata <= '0;
            streak    <= '0;
            state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (mem_req_ready) begin
            if (req_is_write) begin
              // Stores are posted: complete as soon as memory takes the request.
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= '0;
              state         <= ST_IDLE;
            end else begin
              state <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (mem_resp_valid) begin
            if (owner_dc) begin
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= mem_resp_data;
            end else begin
              ic_resp_valid <= 1'b1;
              ic_resp_data  <= mem_resp_data;
            end
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RISCV_MEM_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ic_grant_cnt <= '0;
      dc_grant_cnt <= '0;
      ic_stall_cnt <= '0;
    end else begin
      if (ic_accept) begin
        ic_grant_cnt <= ic_grant_cnt + 32'd1;
      end
      if (dc_accept) begin
        dc_grant_cnt <= dc_grant_cnt + 32'd1;
      end
      if (ic_req_valid && !ic_req_ready) begin
        ic_stall_cnt <= ic_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed self-checking bench for riscv_mem_arbiter

module tb_riscv_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [31:0] dc_req_addr;
  logic [3:0]  dc_req_we;
  logic [31:0] dc_req_wdata;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_we;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;
`ifdef RISCV_MEM_ARB_PERF_EN
  logic [31:0] ic_grant_cnt;
  logic [31:0] dc_grant_cnt;
  logic [31:0] ic_stall_cnt;
`endif

  int checks;
  int failures;
  logic [9:0] ic_order;

  riscv_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_DC_STREAK(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ic_req_valid(ic_req_valid),
    .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid),
    .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid),
    .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we),
    .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid),
    .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .busy(busy)
`ifdef RISCV_MEM_ARB_PERF_EN
    ,
    .ic_grant_cnt(ic_grant_cnt),
    .dc_grant_cnt(dc_grant_cnt),
    .ic_stall_cnt(ic_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    ic_order       = 10'b10_0001_0000;
    reset          = 1'b1;
    ic_req_valid   = 1'b0;
    ic_req_addr    = '0;
    dc_req_valid   = 1'b0;
    dc_req_addr    = '0;
    dc_req_we      = '0;
    dc_req_wdata   = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_ic_resp_valid", ic_resp_valid, 0);
    chk("rst_dc_resp_valid", dc_resp_valid, 0);
    chk("rst_ic_resp_data", ic_resp_data, 0);
    chk("rst_dc_resp_data", dc_resp_data, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_we", mem_req_we, 0);
    chk("rst_mem_req_wdata", mem_req_wdata, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // ic read, 3-cycle latency
    ic_req_valid  = 1'b1;
    ic_req_addr   = 32'h0000_2000;
    mem_req_ready = 1'b1;
    #1;
    chk("t1_ic_ready", ic_req_ready, 1);
    chk("t1_dc_ready", dc_req_ready, 0);
    tick();
    ic_req_valid = 1'b0;
    ic_req_addr  = '0;
    #1;
    chk("t1_req_valid", mem_req_valid, 1);
    chk("t1_req_addr", mem_req_addr, 32'h0000_2000);
    chk("t1_req_we", mem_req_we, 0);
    chk("t1_busy_req", busy, 1);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    #1;
    chk("t1_req_valid_resp", mem_req_valid, 0);
    chk("t1_busy_resp", busy, 1);
    chk("t1_no_early_pulse", ic_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #1;
    chk("t1_ic_resp_valid", ic_resp_valid, 1);
    chk("t1_ic_resp_data", ic_resp_data, 32'hDEAD_BEEF);
    chk("t1_dc_resp_valid", dc_resp_valid, 0);
    chk("t1_busy_done", busy, 0);
    tick();
    #1;
    chk("t1_pulse_end", ic_resp_valid, 0);
    chk("t1_data_hold", ic_resp_data, 32'hDEAD_BEEF);

    // dc load
    dc_req_valid = 1'b1;
    dc_req_addr  = 32'h0000_0100;
    dc_req_we    = 4'b0000;
    #1;
    chk("t2_dc_ready", dc_req_ready, 1);
    chk("t2_ic_ready", ic_req_ready, 0);
    tick();
    dc_req_valid = 1'b0;
    #1;
    chk("t2_req_addr", mem_req_addr, 32'h0000_0100);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t2_dc_resp_valid", dc_resp_valid, 1);
    chk("t2_dc_resp_data", dc_resp_data, 32'hCAFE_F00D);
    chk("t2_ic_resp_valid", ic_resp_valid, 0);
    chk("t2_ic_data_hold", ic_resp_data, 32'hDEAD_BEEF);

    // dc store with memory back-pressure
    dc_req_valid  = 1'b1;
    dc_req_addr   = 32'h1000_0004;
    dc_req_we     = 4'b0011;
    dc_req_wdata  = 32'h1234_5678;
    mem_req_ready = 1'b0;
    #1;
    chk("t3_dc_ready", dc_req_ready, 1);
    tick();
    dc_req_valid = 1'b0;
    dc_req_addr  = '0;
    dc_req_we    = '0;
    dc_req_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_valid", mem_req_valid, 1);
      chk("t3_hold_addr", mem_req_addr, 32'h1000_0004);
      chk("t3_hold_we", mem_req_we, 4'b0011);
      chk("t3_hold_wdata", mem_req_wdata, 32'h1234_5678);
      chk("t3_hold_busy", busy, 1);
      chk("t3_hold_no_resp", dc_resp_valid, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("t3_still_req", mem_req_valid, 1);
    tick();
    #1;
    chk("t3_dc_resp_valid", dc_resp_valid, 1);
    chk("t3_dc_resp_data", dc_resp_data, 0);
    chk("t3_busy_done", busy, 0);
    chk("t3_req_dropped", mem_req_valid, 0);
    tick();
    #1;
    chk("t3_pulse_end", dc_resp_valid, 0);

    // Streak limit: both requesters continuously valid
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_3000;
    dc_req_valid = 1'b1;
    dc_req_addr  = 32'h0000_0200;
    dc_req_we    = 4'b0000;
    for (int n = 0; n < 10; n++) begin
      #1;
      chk("t4_ic_grant", ic_req_ready, ic_order[n]);
      chk("t4_dc_grant", dc_req_ready, !ic_order[n]);
      tick();
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_1000 + n;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      chk("t4_ic_resp_valid", ic_resp_valid, ic_order[n]);
      chk("t4_dc_resp_valid", dc_resp_valid, !ic_order[n]);
      if (ic_order[n]) chk("t4_ic_resp_data", ic_resp_data, 32'h0000_1000 + n);
      else             chk("t4_dc_resp_data", dc_resp_data, 32'h0000_1000 + n);
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;

    // Spurious memory responses in IDLE and REQ
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0055;
    tick();
    #1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_ic_pulse", ic_resp_valid, 0);
    chk("t5_idle_dc_pulse", dc_resp_valid, 0);
    chk("t5_idle_ic_data", ic_resp_data, 32'h0000_1009);
    chk("t5_idle_dc_data", dc_resp_data, 32'h0000_1008);
    ic_req_valid  = 1'b1;
    ic_req_addr   = 32'h0000_2400;
    mem_req_ready = 1'b0;
    tick();
    ic_req_valid = 1'b0;
    #1;
    chk("t5_req_valid", mem_req_valid, 1);
    tick();
    #1;
    chk("t5_req_stays", mem_req_valid, 1);
    chk("t5_req_no_pulse", ic_resp_valid, 0);
    chk("t5_req_busy", busy, 1);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    #1;
    chk("t5_in_resp", mem_req_valid, 0);
    chk("t5_resp_busy", busy, 1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hA5A5_0001;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t5_ic_resp_valid", ic_resp_valid, 1);
    chk("t5_ic_resp_data", ic_resp_data, 32'hA5A5_0001);

    // Reset in RESP, late memory response ignored
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_3000;
    tick();
    ic_req_valid = 1'b0;
    tick();
    #1;
    chk("t6_in_resp", busy, 1);
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0077;
    #1;
    chk("t6_ic_resp_valid", ic_resp_valid, 0);
    chk("t6_dc_resp_valid", dc_resp_valid, 0);
    chk("t6_ic_resp_data", ic_resp_data, 0);
    chk("t6_dc_resp_data", dc_resp_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_req_addr", mem_req_addr, 0);
    chk("t6_req_valid", mem_req_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t6_late_no_pulse", ic_resp_valid, 0);
    chk("t6_late_busy", busy, 0);
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_4000;
    #1;
    chk("t6_next_ready", ic_req_ready, 1);
    tick();
    ic_req_valid = 1'b0;
    #1;
    chk("t6_next_addr", mem_req_addr, 32'h0000_4000);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0099;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("t6_next_resp_valid", ic_resp_valid, 1);
    chk("t6_next_resp_data", ic_resp_data, 32'h0000_0099);

`ifdef RISCV_MEM_ARB_PERF_EN
    // Counters: 3 dc grants with ic waiting (3 stall cycles each),
    // then 5 ic grants (REQ and RESP stall cycles each) -> 9 + 10 = 19
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("p_ic_grant_rst", ic_grant_cnt, 0);
    chk("p_dc_grant_rst", dc_grant_cnt, 0);
    chk("p_ic_stall_rst", ic_stall_cnt, 0);
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    dc_req_we    = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
    end
    dc_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
    end
    ic_req_valid = 1'b0;
    #1;
    chk("p_ic_grant", ic_grant_cnt, 5);
    chk("p_dc_grant", dc_grant_cnt, 3);
    chk("p_ic_stall", ic_stall_cnt, 19);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
